// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply/divide unit producing the 64-bit {HI, LO} value for the Z register.
// Build option: define BIT_PAIR_EN for radix-4 bit-pair Booth multiply (16 iterations instead of 32).
module mul_div_unit #(
  parameter int         WIDTH  = 32,
  parameter logic [4:0] OP_MUL = 5'b01111,
  parameter logic [4:0] OP_DIV = 5'b10000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [4:0]           op_code,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   z_out
);

  // Two guard bits keep Booth partial sums (up to +/-2A) and the shifted remainder from overflowing.
  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH) + 1;
`ifdef BIT_PAIR_EN
  localparam int MUL_ITERS = WIDTH / 2;
`else
  localparam int MUL_ITERS = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     is_div_q, is_div_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]         q_q, q_d;
  logic                     qm1_q, qm1_d;
  logic [WIDTH-1:0]         m_q, m_d;
  logic                     neg_quo_q, neg_quo_d;
  logic                     neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]       z_q, z_d;
  logic                     dbz_q, dbz_d;
  logic                     busy_q, done_q;

  logic signed [AW-1:0]     m_ext;
  logic signed [AW-1:0]     bsum;
  logic signed [AW-1:0]     b_acc;
  logic [WIDTH-1:0]         b_q;
  logic                     b_qm1;
  logic signed [AW-1:0]     rem_sh;
  logic signed [AW-1:0]     diff;
  logic signed [AW-1:0]     d_acc;
  logic [WIDTH-1:0]         d_q;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign m_ext = $signed({{2{m_q[WIDTH-1]}}, m_q});

  // Booth step: add/subtract multiples of the multiplicand, then arithmetic right shift of {acc, Q, q-1}.
`ifdef BIT_PAIR_EN
  logic signed [AW-1:0] m2;
  assign m2 = m_ext <<< 1;

  always_comb begin
    bsum = acc_q;
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: bsum = acc_q + m_ext;
      3'b011:         bsum = acc_q + m2;
      3'b100:         bsum = acc_q - m2;
      3'b101, 3'b110: bsum = acc_q - m_ext;
      default:        bsum = acc_q;
    endcase
    b_acc = {{2{bsum[AW-1]}}, bsum[AW-1:2]};
    b_q   = {bsum[1:0], q_q[WIDTH-1:2]};
    b_qm1 = q_q[1];
  end
`else
  always_comb begin
    bsum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   bsum = acc_q + m_ext;
      2'b10:   bsum = acc_q - m_ext;
      default: bsum = acc_q;
    endcase
    b_acc = {bsum[AW-1], bsum[AW-1:1]};
    b_q   = {bsum[0], q_q[WIDTH-1:1]};
    b_qm1 = q_q[0];
  end
`endif

  // Restoring division step on magnitudes: remainder lives in acc, quotient bits shift into Q.
  always_comb begin
    rem_sh = {acc_q[AW-2:0], q_q[WIDTH-1]};
    diff   = rem_sh - $signed({2'b00, m_q});
    if (diff[AW-1]) begin
      d_acc = rem_sh;
      d_q   = {q_q[WIDTH-2:0], 1'b0};
    end else begin
      d_acc = diff;
      d_q   = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    z_d       = z_q;
    dbz_d     = dbz_q;

    case (state_q)
      IDLE: begin
        if (start && op_code == OP_MUL) begin
          is_div_d = 1'b0;
          m_d      = a_in;
          q_d      = b_in;
          acc_d    = '0;
          qm1_d    = 1'b0;
          cnt_d    = '0;
          dbz_d    = 1'b0;
          state_d  = CALC;
        end else if (start && op_code == OP_DIV) begin
          if (b_in == '0) begin
            z_d     = {a_in, {WIDTH{1'b1}}};
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            is_div_d  = 1'b1;
            m_d       = magnitude(b_in);
            q_d       = magnitude(a_in);
            neg_quo_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            neg_rem_d = a_in[WIDTH-1];
            acc_d     = '0;
            qm1_d     = 1'b0;
            cnt_d     = '0;
            dbz_d     = 1'b0;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_d = d_acc;
          q_d   = d_q;
          if (cnt_q == CW'(WIDTH - 1)) state_d = FIXUP;
        end else begin
          acc_d = b_acc;
          q_d   = b_q;
          qm1_d = b_qm1;
          if (cnt_q == CW'(MUL_ITERS - 1)) begin
            z_d     = {b_acc[WIDTH-1:0], b_q};
            state_d = DONE;
          end
        end
      end
      FIXUP: begin
        z_d     = {cond_neg(acc_q[WIDTH-1:0], neg_rem_q), cond_neg(q_q, neg_quo_q)};
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the state, so they trail the state register by one edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      z_q       <= '0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      z_q       <= z_d;
      dbz_q     <= dbz_d;
      busy_q    <= (state_q != IDLE);
      done_q    <= (state_q == DONE);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign z_out       = z_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table plus scoreboard, with protocol and reset sequences.
module tb_mul_div_unit;

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
`ifdef BIT_PAIR_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 34;
  localparam int DBZ_LAT = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  op_code;
  logic [31:0] a_in, b_in;
  logic        busy, done, div_by_zero;
  logic [63:0] z_out;

  mul_div_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_code(op_code),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .z_out(z_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [63:0] z;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[12];
  int          total = 0;
  int          bad = 0;
  logic [63:0] last_z;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [4:0] op, input logic [31:0] b);
    if (op == OP_DIV) return (b == 32'h0) ? DBZ_LAT : DIV_LAT;
    return MUL_LAT;
  endfunction

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] z, input logic dbz, input int poke_at);
    exp_t e;
    int   n;
    logic got, busy_ok;
    e.z = z; e.dbz = dbz; e.lat = lat_of(op, b);
    @(negedge clk);
    start = 1'b1; op_code = op; a_in = a; b_in = b;
    sb.push_back(e);
    @(posedge clk); #1;
    chk("dbz_at_accept", div_by_zero, dbz);
    start = 1'b0; a_in = $urandom; b_in = $urandom; op_code = 5'($urandom);
    n = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && n < 200) begin
      @(posedge clk); n++; #1;
      if (n == poke_at) begin
        start = 1'b1; op_code = OP_MUL; a_in = 32'd7; b_in = 32'd9;
      end else begin
        start = 1'b0;
      end
      if (!busy) busy_ok = 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("latency", n, e.lat);
      chk("busy_held", busy_ok, 1'b1);
      chk("z_out", z_out, e.z);
      chk("div_by_zero", div_by_zero, e.dbz);
    end
    @(posedge clk); #1;
    chk("busy_fall", busy, 1'b0);
    chk("done_pulse", done, 1'b0);
    last_z = e.z;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0]        a, b;
    logic signed [63:0] p;
    int                 sa, sbv, q, r;
    logic               busy_seen, done_seen;

    reset_n = 1'b0; start = 1'b0; op_code = '0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dbz", div_by_zero, 1'b0);
    chk("rst_z", z_out, 64'h0);
    @(negedge clk); reset_n = 1'b1;

    tbl[0]  = '{OP_MUL, 32'h00000012, 32'h00000014, 64'h00000000_00000168, 1'b0};
    tbl[1]  = '{OP_MUL, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 1'b0};
    tbl[2]  = '{OP_MUL, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0};
    tbl[3]  = '{OP_DIV, 32'h00000014, 32'h00000012, 64'h00000002_00000001, 1'b0};
    tbl[4]  = '{OP_DIV, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0};
    tbl[5]  = '{OP_DIV, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF, 1'b1};
    tbl[6]  = '{OP_MUL, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 1'b0};
    tbl[7]  = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0};
    tbl[8]  = '{OP_DIV, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0};
    tbl[9]  = '{OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 1'b0};
    tbl[10] = '{OP_MUL, 32'h00000000, 32'h12345678, 64'h00000000_00000000, 1'b0};
    tbl[11] = '{OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0};

    for (int i = 0; i < 12; i++)
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].z, tbl[i].dbz, 0);

    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      p = longint'($signed(a)) * longint'($signed(b));
      do_op(OP_MUL, a, b, p, 1'b0, 0);
      a = $urandom; b = $urandom;
      while (b == 32'h0 || b == 32'hFFFFFFFF) b = $urandom;
      sa = a; sbv = b; q = sa / sbv; r = sa % sbv;
      do_op(OP_DIV, a, b, {32'(r), 32'(q)}, 1'b0, 0);
    end

    // A second start mid-calculation must not disturb the running multiply.
    do_op(OP_MUL, 32'h12, 32'h14, 64'h168, 1'b0, 5);

    // Unrecognised op_code is ignored entirely.
    @(negedge clk);
    start = 1'b1; op_code = 5'b00011; a_in = 32'h55; b_in = 32'h66;
    @(negedge clk);
    start = 1'b0;
    busy_seen = 1'b0; done_seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      busy_seen |= busy;
      done_seen |= done;
    end
    chk("bad_op_busy", busy_seen, 1'b0);
    chk("bad_op_done", done_seen, 1'b0);
    chk("bad_op_z", z_out, last_z);

    // Reset asserted at edge 10 of a multiply.
    @(negedge clk);
    start = 1'b1; op_code = OP_MUL; a_in = 32'h1234; b_in = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("busy_before_rst", busy, 1'b1);
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_z", z_out, 64'h0);
    chk("midrst_dbz", div_by_zero, 1'b0);
    @(negedge clk); reset_n = 1'b1;
    last_z = '0;
    do_op(OP_MUL, 32'hFFFF0000, 32'h00010000, 64'hFFFFFFFF_00000000, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
